// File: rtl/spi_slave_core_if.sv
// Host-side (CPU register file) view of the SPI responder: mode select,
// transmit pending register and receive word.
interface spi_slave_core_if #(
  parameter int D_WIDTH = 8
);
  logic               cpol;
  logic               cpha;
  logic [D_WIDTH-1:0] tx_data;
  logic               tx_load;
  logic               tx_empty;
  logic               tx_underrun;
  logic [D_WIDTH-1:0] rx_data;
  logic               rx_valid;
  logic               busy;

  modport master (
    output cpol, cpha, tx_data, tx_load,
    input  tx_empty, tx_underrun, rx_data, rx_valid, busy
  );

  modport slave (
    input  cpol, cpha, tx_data, tx_load,
    output tx_empty, tx_underrun, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// SPI responder oversampled by the system clock: synchronizes sclk/ss_n/mosi,
// shifts D_WIDTH-bit words MSB-first in all four cpol/cpha modes.
module spi_slave_core #(
  parameter int D_WIDTH     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  spi_slave_core_if.slave host,
  input  logic            sclk,
  input  logic            ss_n,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe
);
  localparam int            CW       = $clog2(D_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(D_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                 sclk_prev, ss_prev;
  logic                 cpol_q, cpha_q;
  logic [CW-1:0]        bit_cnt;
  logic [D_WIDTH-1:0]   rx_shift, tx_shift, pending;
  logic                 word_done, wrap_pending, seen_sample;

  logic sclk_s, ss_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic do_load, do_shift;

  // NOTE: ss_n synchronizer resets to 1 so leaving reset never looks like a
  // select assertion; the pin must be seen going low after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ss_fall     = ss_prev & ~ss_s;
    ss_rise     = ~ss_prev & ss_s;
    sclk_rise   = ~sclk_prev & sclk_s;
    sclk_fall   = sclk_prev & ~sclk_s;
    lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trail_edge : lead_edge;
    shift_edge  = cpha_q ? lead_edge : trail_edge;
    do_load     = 1'b0;
    do_shift    = 1'b0;
    if (state == IDLE) begin
      do_load = ss_fall && !host.cpha;
    end else if (!ss_rise && shift_edge) begin
      // cpha=1 loads on the first shift edge of each word; cpha=0 preloads
      // at select and then reloads on the shift edge after a word completes.
      if (cpha_q) begin
        do_load  = (bit_cnt == '0);
        do_shift = (bit_cnt != '0);
      end else begin
        do_load  = seen_sample && wrap_pending;
        do_shift = seen_sample && !wrap_pending;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cpol_q           <= 1'b0;
      cpha_q           <= 1'b0;
      bit_cnt          <= '0;
      rx_shift         <= '0;
      tx_shift         <= '0;
      pending          <= '0;
      word_done        <= 1'b0;
      wrap_pending     <= 1'b0;
      seen_sample      <= 1'b0;
      host.rx_data     <= '0;
      host.rx_valid    <= 1'b0;
      host.tx_empty    <= 1'b1;
      host.tx_underrun <= 1'b0;
      host.busy        <= 1'b0;
      miso             <= 1'b0;
      miso_oe          <= 1'b0;
    end else begin
      host.rx_valid    <= 1'b0;
      host.tx_underrun <= 1'b0;
      word_done        <= 1'b0;

      // Word commit runs regardless of state so a word that completes as
      // ss_n rises is still delivered.
      if (word_done) begin
        host.rx_data  <= rx_shift;
        host.rx_valid <= 1'b1;
        bit_cnt       <= '0;
      end

      if (do_load) begin
        if (!host.tx_empty) begin
          tx_shift      <= pending;
          miso          <= pending[D_WIDTH-1];
          host.tx_empty <= 1'b1;
        end else begin
          tx_shift         <= '0;
          miso             <= 1'b0;
          host.tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_shift <= {tx_shift[D_WIDTH-2:0], 1'b0};
        miso     <= tx_shift[D_WIDTH-2];
      end

      // A host write wins over a same-cycle consume of the pending word.
      if (host.tx_load) begin
        pending       <= host.tx_data;
        host.tx_empty <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state        <= ACTIVE;
            cpol_q       <= host.cpol;
            cpha_q       <= host.cpha;
            bit_cnt      <= '0;
            seen_sample  <= 1'b0;
            wrap_pending <= 1'b0;
            host.busy    <= 1'b1;
            miso_oe      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sample_edge) begin
            rx_shift     <= {rx_shift[D_WIDTH-2:0], mosi_s};
            bit_cnt      <= bit_cnt + 1'b1;
            seen_sample  <= 1'b1;
            wrap_pending <= (bit_cnt == LAST_BIT);
            word_done    <= (bit_cnt == LAST_BIT);
          end else if (do_load) begin
            wrap_pending <= 1'b0;
          end
          if (ss_rise) begin
            state     <= IDLE;
            host.busy <= 1'b0;
            miso_oe   <= 1'b0;
            miso      <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI responder (slave) and the counterpart to the team's SPI master core. It oversamples the external sclk, ss_n and mosi pins with the system clock, so there is no second clock domain. It shifts in D_WIDTH-bit words MSB-first on mosi and shifts out a preloaded word on miso, for all four cpol/cpha modes, including back-to-back words under one ss_n assertion. It sits between the pads and a CPU-side register file.

Parameters:
D_WIDTH, 8, word length in bits; minimum 2.
SYNC_STAGES, 2, synchronizer flop depth on sclk, ss_n and mosi; minimum 2.

Ports:
clock  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
cpol  input  1  sclk idle level; latched at ss_n assertion.
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at ss_n assertion.
tx_data  input  D_WIDTH  next word to transmit.
tx_load  input  1  one-cycle strobe: write tx_data into the pending register.
tx_empty  output  1  1 = pending register free.
tx_underrun  output  1  one-cycle pulse: a word was needed while pending was empty.
rx_data  output  D_WIDTH  last complete received word.
rx_valid  output  1  one-cycle pulse: rx_data updated.
busy  output  1  1 while ss_n (synchronized) is asserted.
sclk  input  1  SPI clock pin.
ss_n  input  1  slave select pin, active-low.
mosi  input  1  master-out data pin.
miso  output  1  slave-out data.
miso_oe  output  1  tristate enable for the miso pad.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, tx_empty=1, tx_underrun=0, miso=0, miso_oe=0, busy=0, FSM=IDLE, bit counter=0.
- Synchronization: sclk, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk by comparing it with its previous value.
  - Synchronizer flops reset to sclk=0, ss_n=1, mosi=0.
- Edge definitions (using cpol/cpha as latched):
  - Leading edge = transition away from the cpol level.
  - Sample edge = leading edge if cpha=0, trailing edge if cpha=1.
  - Shift edge = the other edge.
- FSM states: IDLE and ACTIVE.
- IDLE:
  - Enters ACTIVE on a synchronized ss_n falling edge.
  - On entry: latch cpol/cpha, clear the bit counter, busy=1, miso_oe=1.
  - If cpha=0, perform a TX load (defined below) in the same cycle.
- TX load:
  - If tx_empty=0: shift register <= pending, tx_empty <= 1.
  - Otherwise: shift register <= 0 and pulse tx_underrun.
  - miso = shift register MSB, registered.
  - If tx_load coincides with a TX load, the old pending word is consumed, tx_data becomes the new pending word, and tx_empty stays 0.
  - tx_load while tx_empty=0 overwrites pending; last write wins.
- Sample edge:
  - rx_shift <= {rx_shift[D_WIDTH-2:0], mosi_sync}; bit counter increments.
  - When the counter reaches D_WIDTH: on the next cycle rx_data <= completed word and rx_valid=1 for one cycle; counter <= 0.
  - A new word received before the host reads simply overwrites rx_data.
- Shift edge:
  - cpha=1: if the counter is 0, perform a TX load; else shift left, miso = new MSB.
  - cpha=0: if the previous sample completed a word (counter just wrapped), perform a TX load for the next word; else shift left.
  - No shift occurs before the first sample edge of a transaction.
- ss_n deassertion (synchronized rising edge), at any point:
  - Return to IDLE; busy=0, miso_oe=0, miso=0, counter=0.
  - A partial word is discarded with no rx_valid. The pending register is untouched.
  - If the deassertion arrives in the same cycle as word completion, rx_valid still fires.
- While ss_n is deasserted, sclk activity is ignored.
- Latency: rx_valid rises SYNC_STAGES+2 clock cycles after the final sample edge at the pin.
- Timing constraint: sclk high time and low time must each be at least SYNC_STAGES+2 clock periods. Behaviour is unspecified below this.

Test Plan:
- Mode 0, preload 0xA5, master sends 0x3C → rx_data=0x3C with a single rx_valid pulse; master receives 0xA5; tx_empty back to 1.
- All four modes (cpol, cpha = 00, 01, 10, 11) → each exchanges 0x81/0x7E correctly in both directions, with ~2 clocks before/after each edge and half-period = SYNC_STAGES+2.
- Two words under one ss_n: preload 0x11, reload 0x22 from the first rx_valid → master receives 0x11 then 0x22; rx_valid fires twice with 0xC3, then 0x5A.
- No preload → master receives 0x00 and tx_underrun pulses exactly once per starved word.
- ss_n deasserted after 5 bits → no rx_valid, rx_data unchanged; the next full transaction of 0xF0 is received correctly.
- reset_n asserted mid-word → all outputs return to reset values immediately; after release, a clean transaction of 0x96 succeeds.
